// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and issue bundle between the ALU reservation station and its neighbours.
// The master side drives dispatch/broadcast/flush; the slave side (the station) returns full and the issue packet.
interface alu_rs_if #(
    parameter int NICK_W = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              iDP_en;
    logic [ADDR_W-1:0] iDP_pc;
    logic [OP_W-1:0]   iDP_op;
    logic [DATA_W-1:0] iDP_imm;
    logic [NICK_W-1:0] iDP_rd_nick;
    logic              iDP_rs1_rdy;
    logic              iDP_rs2_rdy;
    logic [NICK_W-1:0] iDP_rs1_nick;
    logic [NICK_W-1:0] iDP_rs2_nick;
    logic [DATA_W-1:0] iDP_rs1_dt;
    logic [DATA_W-1:0] iDP_rs2_dt;

    logic              iEX_en;
    logic [NICK_W-1:0] iEX_nick;
    logic [DATA_W-1:0] iEX_dt;
    logic              iLSB_en;
    logic [NICK_W-1:0] iLSB_nick;
    logic [DATA_W-1:0] iLSB_dt;
    logic              iROB_clr;

    logic              oRS_full;
    logic              oRS_en;
    logic [ADDR_W-1:0] oRS_pc;
    logic [OP_W-1:0]   oRS_op;
    logic [DATA_W-1:0] oRS_imm;
    logic [NICK_W-1:0] oRS_rd_nick;
    logic [DATA_W-1:0] oRS_rs1_dt;
    logic [DATA_W-1:0] oRS_rs2_dt;

    modport master (
        output iDP_en, iDP_pc, iDP_op, iDP_imm, iDP_rd_nick,
               iDP_rs1_rdy, iDP_rs2_rdy, iDP_rs1_nick, iDP_rs2_nick, iDP_rs1_dt, iDP_rs2_dt,
               iEX_en, iEX_nick, iEX_dt, iLSB_en, iLSB_nick, iLSB_dt, iROB_clr,
        input  oRS_full, oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt
    );

    modport slave (
        input  iDP_en, iDP_pc, iDP_op, iDP_imm, iDP_rd_nick,
               iDP_rs1_rdy, iDP_rs2_rdy, iDP_rs1_nick, iDP_rs2_nick, iDP_rs1_dt, iDP_rs2_dt,
               iEX_en, iEX_nick, iEX_dt, iLSB_en, iLSB_nick, iLSB_dt, iROB_clr,
        output oRS_full, oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until both operands resolve via CDB snoop, issues one per cycle registered.
// Ready-at-dispatch op issues one edge after dispatch; dispatcher must stall on oRS_full (overflow is dropped).
module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int NICK_W  = 4,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    alu_rs_if.slave  bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [NICK_W-1:0] rd;
    } hdr_t;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] r1;
    logic [RS_SIZE-1:0] r2;
    hdr_t               ent_hdr [RS_SIZE];
    logic [NICK_W-1:0]  q1      [RS_SIZE];
    logic [NICK_W-1:0]  q2      [RS_SIZE];
    logic [DATA_W-1:0]  d1      [RS_SIZE];
    logic [DATA_W-1:0]  d2      [RS_SIZE];

    logic               free_vld;
    logic [IDX_W-1:0]   free_idx;
    logic               iss_vld;
    logic [IDX_W-1:0]   iss_idx;
    logic               full;
    logic               dp_take;

    logic [RS_SIZE-1:0] wake1;
    logic [RS_SIZE-1:0] wake2;
    logic [DATA_W-1:0]  wdat1   [RS_SIZE];
    logic [DATA_W-1:0]  wdat2   [RS_SIZE];

    logic               dp_ex1, dp_ex2, dp_lsb1, dp_lsb2;
    logic               dp_r1, dp_r2;
    logic [DATA_W-1:0]  dp_d1, dp_d2;

    logic               pkt_en;
    hdr_t               pkt_hdr;
    logic [DATA_W-1:0]  pkt_d1;
    logic [DATA_W-1:0]  pkt_d2;

    assign full    = &busy;
    // Full is sampled from pre-edge state, so a slot freed by this edge's issue is not reusable yet.
    assign dp_take = bus.iDP_en && !full && !bus.iROB_clr && free_vld;

    // Descending scans: the last hit written is the lowest index.
    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        iss_vld  = 1'b0;
        iss_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (busy[i] && r1[i] && r2[i]) begin
                iss_vld = 1'b1;
                iss_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            logic ex1, ex2, lsb1, lsb2;
            ex1      = bus.iEX_en  && (bus.iEX_nick  == q1[i]);
            lsb1     = bus.iLSB_en && (bus.iLSB_nick == q1[i]);
            ex2      = bus.iEX_en  && (bus.iEX_nick  == q2[i]);
            lsb2     = bus.iLSB_en && (bus.iLSB_nick == q2[i]);
            wake1[i] = busy[i] && !r1[i] && (ex1 || lsb1);
            wake2[i] = busy[i] && !r2[i] && (ex2 || lsb2);
            wdat1[i] = ex1 ? bus.iEX_dt : bus.iLSB_dt;
            wdat2[i] = ex2 ? bus.iEX_dt : bus.iLSB_dt;
        end
    end

    always_comb begin
        dp_ex1  = bus.iEX_en  && (bus.iEX_nick  == bus.iDP_rs1_nick);
        dp_lsb1 = bus.iLSB_en && (bus.iLSB_nick == bus.iDP_rs1_nick);
        dp_ex2  = bus.iEX_en  && (bus.iEX_nick  == bus.iDP_rs2_nick);
        dp_lsb2 = bus.iLSB_en && (bus.iLSB_nick == bus.iDP_rs2_nick);
        dp_r1   = bus.iDP_rs1_rdy || dp_ex1 || dp_lsb1;
        dp_r2   = bus.iDP_rs2_rdy || dp_ex2 || dp_lsb2;
        dp_d1   = bus.iDP_rs1_rdy ? bus.iDP_rs1_dt : (dp_ex1 ? bus.iEX_dt : bus.iLSB_dt);
        dp_d2   = bus.iDP_rs2_rdy ? bus.iDP_rs2_dt : (dp_ex2 ? bus.iEX_dt : bus.iLSB_dt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            pkt_en  <= 1'b0;
            pkt_hdr <= '0;
            pkt_d1  <= '0;
            pkt_d2  <= '0;
        end else if (rdy) begin
            if (bus.iROB_clr) begin
                busy    <= '0;
                pkt_en  <= 1'b0;
                pkt_hdr <= '0;
                pkt_d1  <= '0;
                pkt_d2  <= '0;
            end else begin
                if (iss_vld) begin
                    pkt_en        <= 1'b1;
                    pkt_hdr       <= ent_hdr[iss_idx];
                    pkt_d1        <= d1[iss_idx];
                    pkt_d2        <= d2[iss_idx];
                    busy[iss_idx] <= 1'b0;
                end else begin
                    pkt_en  <= 1'b0;
                    pkt_hdr <= '0;
                    pkt_d1  <= '0;
                    pkt_d2  <= '0;
                end
                if (dp_take) begin
                    busy[free_idx] <= 1'b1;
                end
            end
        end
    end

    // Payload needs no reset: every field is qualified by busy.
    always_ff @(posedge clk) begin
        if (rdy && !bus.iROB_clr) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wake1[i]) begin
                    r1[i] <= 1'b1;
                    d1[i] <= wdat1[i];
                end
                if (wake2[i]) begin
                    r2[i] <= 1'b1;
                    d2[i] <= wdat2[i];
                end
            end
            if (dp_take) begin
                ent_hdr[free_idx] <= '{pc: bus.iDP_pc, op: bus.iDP_op, imm: bus.iDP_imm, rd: bus.iDP_rd_nick};
                r1[free_idx]      <= dp_r1;
                r2[free_idx]      <= dp_r2;
                q1[free_idx]      <= bus.iDP_rs1_nick;
                q2[free_idx]      <= bus.iDP_rs2_nick;
                d1[free_idx]      <= dp_d1;
                d2[free_idx]      <= dp_d2;
            end
        end
    end

    assign bus.oRS_full    = full;
    assign bus.oRS_en      = pkt_en;
    assign bus.oRS_pc      = pkt_hdr.pc;
    assign bus.oRS_op      = pkt_hdr.op;
    assign bus.oRS_imm     = pkt_hdr.imm;
    assign bus.oRS_rd_nick = pkt_hdr.rd;
    assign bus.oRS_rs1_dt  = pkt_d1;
    assign bus.oRS_rs2_dt  = pkt_d2;
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the integer ALU path.
- Buffers dispatched ALU/branch/jump ops until both source operands are resolved.
- Resolves operands by snooping the two CDB result channels: ALU/execute and load/store buffer.
- Issues at most one ready op per cycle, as a registered packet, to the execute unit.

Parameters:
RS_SIZE, 16, number of entries (power of two, >=2)
NICK_W, 4, rename tag (ROB index) width
OP_W, 6, internal opcode width
DATA_W, 32, operand/result width
ADDR_W, 32, pc width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; when low all state and outputs hold
iDP_en  in  1  dispatch request
iDP_pc  in  ADDR_W  instruction pc
iDP_op  in  OP_W  opcode
iDP_imm  in  DATA_W  sign-extended immediate
iDP_rd_nick  in  NICK_W  destination tag
iDP_rs1_rdy / iDP_rs2_rdy  in  1 each  operand value already valid
iDP_rs1_nick / iDP_rs2_nick  in  NICK_W each  producer tag when not ready
iDP_rs1_dt / iDP_rs2_dt  in  DATA_W each  operand value when ready
iEX_en, iEX_nick, iEX_dt  in  1/NICK_W/DATA_W  execute-unit broadcast
iLSB_en, iLSB_nick, iLSB_dt  in  1/NICK_W/DATA_W  load/store broadcast
iROB_clr  in  1  mispredict flush
oRS_full  out  1  no free entry (combinational from state)
oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt  out  1/ADDR_W/OP_W/DATA_W/NICK_W/DATA_W/DATA_W  issue packet to execute

Behaviour:
- Reset (async, any time): all entries not busy; all outputs 0; oRS_full 0.
- rdy low: no state change, outputs hold; rst still acts.
- Per entry: busy, pc, op, imm, rd_nick, and for each source a ready bit, a tag and a value.
- Dispatch:
  - Accepted at the edge when iDP_en=1, oRS_full=0 and iROB_clr=0.
  - Written to the lowest-index free entry.
  - iDP_en with oRS_full=1 is dropped silently; the dispatcher must stall on oRS_full.
- Dispatch bypass: an operand arriving not ready whose tag matches a same-cycle broadcast (iEX_en or iLSB_en high) is stored ready with the broadcast data.
- Wakeup:
  - Each edge, every busy entry compares each not-ready operand tag against iEX_nick (when iEX_en) and iLSB_nick (when iLSB_en).
  - On a match it captures the data and sets ready.
  - If both channels match, EX wins.
  - en=0 channels never match, including tag 0.
- Issue select:
  - Uses registered state only: the lowest-index entry that is busy with both operands ready.
  - At the edge, the output packet is loaded from that entry, oRS_en<=1, and the entry's busy bit is cleared.
  - With no candidate: oRS_en<=0 and all oRS_* data outputs <=0.
- Latency:
  - Op dispatched ready at edge T: oRS_en high in the cycle after edge T+1.
  - Op woken at edge T: same timing.
  - Minimum residency is one cycle.
- Simultaneous issue and dispatch:
  - Allowed when a free entry existed before the edge.
  - A slot freed by issue at edge T is reusable from edge T+1 only; oRS_full is computed before the issue takes effect.
- Flush:
  - iROB_clr=1 at an edge clears all busy bits and sets oRS_en<=0 with data outputs 0.
  - Dispatch and wakeup in that cycle are discarded.
- oRS_full = AND of all busy bits.

Test Plan:
- Reset mid-run with 3 busy entries and oRS_en=1 -> immediately all outputs 0, oRS_full=0, no later issue.
- Dispatch ADDI pc=0x100, rs1 ready dt=5, imm=7, rd_nick=3 at edge T -> oRS_en=1 after edge T+1 with oRS_rs1_dt=5, oRS_imm=7, oRS_rd_nick=3; oRS_en=0 the next cycle.
- Dispatch ADD with rs1 waiting on tag 2 and rs2 waiting on tag 4; then iEX_en nick=2 dt=0x11 followed by iLSB_en nick=4 dt=0x22 -> issued one cycle after the second broadcast with rs1_dt=0x11, rs2_dt=0x22.
- Dispatch with rs1 tag 6 in the same cycle as iEX_en nick=6 dt=9 -> bypass captured; issues at T+1 with rs1_dt=9.
- Fill all 16 entries with unready ops -> oRS_full=1 and a 17th dispatch is dropped. Then wake entries 5 and 2 in the same cycle -> entry 2 issues first, entry 5 the following cycle.
- With 4 busy entries, assert iROB_clr together with iDP_en -> all entries empty, oRS_en=0, nothing issues afterwards. Then rdy=0 for 3 cycles -> outputs frozen.
